// File: rtl/simon_ti_round_ctrl.sv
// Round sequencer for the 3-share TI Simon128/128 datapath.
// Ports: CLK/RSTn, EN/Drdy in; BSY/Dvld/Trig, dp_load/step/last, rnd_idx/z_idx out.
module simon_ti_round_ctrl #(
  parameter int ROUNDS = 68,
  parameter int CPR    = 1,
  parameter int ZLEN   = 62
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       EN,
  input  logic       Drdy,
  output logic       BSY,
  output logic       Dvld,
  output logic       Trig,
  output logic       dp_load,
  output logic       dp_step,
  output logic       dp_last,
  output logic [6:0] rnd_idx,
  output logic [5:0] z_idx
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  localparam logic [6:0] RLAST = 7'(ROUNDS - 1);
  localparam logic [5:0] ZLAST = 6'(ZLEN - 1);
  localparam logic [1:0] SLAST = 2'(CPR - 1);

  state_e     state_q, state_d;
  logic [6:0] rnd_q, rnd_d;
  logic [5:0] z_q, z_d;
  logic [1:0] sub_q, sub_d;
  logic       step;

  assign step = (state_q == RUN) && (sub_q == SLAST);

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    z_d     = z_q;
    sub_d   = sub_q;
    unique case (state_q)
      IDLE: begin
        rnd_d = '0;
        z_d   = '0;
        sub_d = '0;
        if (Drdy && EN) state_d = LOAD;
      end
      LOAD: begin
        rnd_d   = '0;
        z_d     = '0;
        sub_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (step) begin
          sub_d = '0;
          // Final round keeps its index visible through DONE.
          if (rnd_q == RLAST) begin
            state_d = DONE;
          end else begin
            rnd_d = rnd_q + 7'd1;
            z_d   = (z_q == ZLAST) ? 6'd0 : z_q + 6'd1;
          end
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      DONE: begin
        rnd_d   = '0;
        z_d     = '0;
        sub_d   = '0;
        state_d = (Drdy && EN) ? LOAD : IDLE;
      end
    endcase
    // EN low aborts from anywhere.
    if (!EN) begin
      state_d = IDLE;
      rnd_d   = '0;
      z_d     = '0;
      sub_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      z_q     <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      z_q     <= z_d;
      sub_q   <= sub_d;
    end
  end

  assign BSY     = (state_q == LOAD) || (state_q == RUN);
  assign Dvld    = (state_q == DONE);
  assign dp_load = (state_q == LOAD);
  assign dp_step = step;
  assign dp_last = step && (rnd_q == RLAST);
  assign Trig    = (state_q == RUN) && (rnd_q == 7'd0);
  assign rnd_idx = rnd_q;
  assign z_idx   = z_q;

endmodule

// File: tb/tb_simon_ti_round_ctrl.sv
// Directed bench for simon_ti_round_ctrl.
// Instance a: CPR=1, instance b: CPR=3, shared inputs.
module tb_simon_ti_round_ctrl;

  logic CLK, RSTn, EN, Drdy;
  logic a_BSY, a_Dvld, a_Trig, a_dp_load, a_dp_step, a_dp_last;
  logic [6:0] a_rnd_idx;
  logic [5:0] a_z_idx;
  logic b_BSY, b_Dvld, b_Trig, b_dp_load, b_dp_step, b_dp_last;
  logic [6:0] b_rnd_idx;
  logic [5:0] b_z_idx;

  int n_chk = 0;
  int n_fail = 0;

  simon_ti_round_ctrl #(.ROUNDS(68), .CPR(1), .ZLEN(62)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .Drdy(Drdy),
    .BSY(a_BSY), .Dvld(a_Dvld), .Trig(a_Trig),
    .dp_load(a_dp_load), .dp_step(a_dp_step), .dp_last(a_dp_last),
    .rnd_idx(a_rnd_idx), .z_idx(a_z_idx)
  );

  simon_ti_round_ctrl #(.ROUNDS(68), .CPR(3), .ZLEN(62)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .Drdy(Drdy),
    .BSY(b_BSY), .Dvld(b_Dvld), .Trig(b_Trig),
    .dp_load(b_dp_load), .dp_step(b_dp_step), .dp_last(b_dp_last),
    .rnd_idx(b_rnd_idx), .z_idx(b_z_idx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    EN   = 1'b1;
    Drdy = 1'b0;
    #20;
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    EN   = 1'b1;
    Drdy = 1'b0;
    #1;
    n_chk++;
    if ({a_BSY, a_Dvld, a_Trig, a_dp_load, a_dp_step, a_dp_last,
         a_rnd_idx, a_z_idx, b_BSY, b_Dvld, b_dp_load} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_held: got bsy=%b dvld=%b load=%b rnd=%0d want all 0",
               a_BSY, a_Dvld, a_dp_load, a_rnd_idx);
    end
    #19;
    RSTn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_chk++;
      if ({a_BSY, a_Dvld, a_Trig, a_dp_load, a_dp_step, a_dp_last,
           a_rnd_idx, a_z_idx} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b want 0", i,
                 {a_BSY, a_Dvld, a_Trig, a_dp_load, a_dp_step, a_dp_last,
                  a_rnd_idx, a_z_idx});
      end
    end
  endtask

  task automatic test_nominal();
    do_reset();
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    n_chk++;
    if (a_dp_load !== 1'b1 || a_BSY !== 1'b1 || a_dp_step !== 1'b0 ||
        a_Dvld !== 1'b0 || a_rnd_idx !== 7'd0) begin
      n_fail++;
      $display("FAIL nom_load: got load=%b bsy=%b step=%b dvld=%b rnd=%0d want 1 1 0 0 0",
               a_dp_load, a_BSY, a_dp_step, a_Dvld, a_rnd_idx);
    end
    for (int e = 1; e <= 68; e++) begin
      tick();
      n_chk++;
      if (a_dp_step !== 1'b1 || a_rnd_idx !== 7'(e - 1) ||
          a_z_idx !== 6'((e - 1) % 62) || a_Trig !== (e == 1) ||
          a_dp_last !== (e == 68) || a_BSY !== 1'b1 ||
          a_dp_load !== 1'b0 || a_Dvld !== 1'b0) begin
        n_fail++;
        $display("FAIL nom_run e=%0d: got step=%b rnd=%0d z=%0d trig=%b last=%b bsy=%b ld=%b dv=%b want 1 %0d %0d %b %b 1 0 0",
                 e, a_dp_step, a_rnd_idx, a_z_idx, a_Trig, a_dp_last, a_BSY,
                 a_dp_load, a_Dvld, e - 1, (e - 1) % 62, e == 1, e == 68);
      end
    end
    tick();
    n_chk++;
    if (a_Dvld !== 1'b1 || a_BSY !== 1'b0 || a_rnd_idx !== 7'd67 ||
        a_dp_step !== 1'b0 || a_Trig !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_done: got dvld=%b bsy=%b rnd=%0d step=%b trig=%b want 1 0 67 0 0",
               a_Dvld, a_BSY, a_rnd_idx, a_dp_step, a_Trig);
    end
    tick();
    n_chk++;
    if (a_Dvld !== 1'b0 || a_BSY !== 1'b0 || a_dp_load !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_idle: got dvld=%b bsy=%b load=%b want 0 0 0",
               a_Dvld, a_BSY, a_dp_load);
    end
  endtask

  task automatic test_z_wrap();
    do_reset();
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    for (int e = 1; e <= 68; e++) begin
      tick();
      if (e == 62) begin
        n_chk++;
        if (a_rnd_idx !== 7'd61 || a_z_idx !== 6'd61) begin
          n_fail++;
          $display("FAIL z_61: got rnd=%0d z=%0d want 61 61", a_rnd_idx, a_z_idx);
        end
      end
      if (e == 63) begin
        n_chk++;
        if (a_rnd_idx !== 7'd62 || a_z_idx !== 6'd0) begin
          n_fail++;
          $display("FAIL z_wrap: got rnd=%0d z=%0d want 62 0", a_rnd_idx, a_z_idx);
        end
      end
      if (e == 68) begin
        n_chk++;
        if (a_rnd_idx !== 7'd67 || a_z_idx !== 6'd5) begin
          n_fail++;
          $display("FAIL z_67: got rnd=%0d z=%0d want 67 5", a_rnd_idx, a_z_idx);
        end
      end
    end
    tick();
  endtask

  task automatic test_cpr3();
    int steps;
    steps = 0;
    do_reset();
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    n_chk++;
    if (b_dp_load !== 1'b1 || b_BSY !== 1'b1) begin
      n_fail++;
      $display("FAIL c3_load: got load=%b bsy=%b want 1 1", b_dp_load, b_BSY);
    end
    for (int e = 1; e <= 204; e++) begin
      int k;
      k = e - 1;
      tick();
      if (b_dp_step === 1'b1) steps++;
      n_chk++;
      if (b_dp_step !== (k % 3 == 2) || b_rnd_idx !== 7'(k / 3) ||
          b_Trig !== (k < 3) || b_dp_last !== (k == 203) ||
          b_BSY !== 1'b1 || b_Dvld !== 1'b0) begin
        n_fail++;
        $display("FAIL c3_run k=%0d: got step=%b rnd=%0d trig=%b last=%b bsy=%b dv=%b want %b %0d %b %b 1 0",
                 k, b_dp_step, b_rnd_idx, b_Trig, b_dp_last, b_BSY, b_Dvld,
                 k % 3 == 2, k / 3, k < 3, k == 203);
      end
    end
    tick();
    n_chk++;
    if (b_Dvld !== 1'b1 || b_BSY !== 1'b0 || steps != 68) begin
      n_fail++;
      $display("FAIL c3_done: got dvld=%b bsy=%b steps=%0d want 1 0 68",
               b_Dvld, b_BSY, steps);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    for (int e = 1; e <= 68; e++) begin
      tick();
      if (e == 11) Drdy = 1'b1;
      if (e == 12) Drdy = 1'b0;
      n_chk++;
      if (a_dp_load !== 1'b0 || a_Dvld !== 1'b0 || a_BSY !== 1'b1 ||
          a_rnd_idx !== 7'(e - 1)) begin
        n_fail++;
        $display("FAIL busy_ign e=%0d: got ld=%b dv=%b bsy=%b rnd=%0d want 0 0 1 %0d",
                 e, a_dp_load, a_Dvld, a_BSY, a_rnd_idx, e - 1);
      end
    end
    tick();
    n_chk++;
    if (a_Dvld !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_dv1: got dvld=%b want 1", a_Dvld);
    end
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    n_chk++;
    if (a_dp_load !== 1'b1 || a_Dvld !== 1'b0 || a_BSY !== 1'b1 ||
        a_rnd_idx !== 7'd0) begin
      n_fail++;
      $display("FAIL b2b_load: got ld=%b dv=%b bsy=%b rnd=%0d want 1 0 1 0",
               a_dp_load, a_Dvld, a_BSY, a_rnd_idx);
    end
    for (int e = 1; e <= 68; e++) begin
      tick();
      n_chk++;
      if (a_Dvld !== 1'b0 || a_dp_step !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_run e=%0d: got dv=%b step=%b want 0 1",
                 e, a_Dvld, a_dp_step);
      end
    end
    tick();
    n_chk++;
    if (a_Dvld !== 1'b1 || a_rnd_idx !== 7'd67) begin
      n_fail++;
      $display("FAIL b2b_dv2: got dvld=%b rnd=%0d want 1 67", a_Dvld, a_rnd_idx);
    end
    tick();
    n_chk++;
    if (a_Dvld !== 1'b0 || a_BSY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got dvld=%b bsy=%b want 0 0", a_Dvld, a_BSY);
    end
  endtask

  task automatic test_abort();
    int dv;
    int bs;
    do_reset();
    EN   = 1'b0;
    Drdy = 1'b1;
    tick();
    tick();
    Drdy = 1'b0;
    EN   = 1'b1;
    n_chk++;
    if (a_BSY !== 1'b0 || a_dp_load !== 1'b0) begin
      n_fail++;
      $display("FAIL en0_ign: got bsy=%b load=%b want 0 0", a_BSY, a_dp_load);
    end
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    for (int e = 1; e <= 31; e++) tick();
    n_chk++;
    if (a_BSY !== 1'b1 || a_rnd_idx !== 7'd30) begin
      n_fail++;
      $display("FAIL ab_pre: got bsy=%b rnd=%0d want 1 30", a_BSY, a_rnd_idx);
    end
    EN = 1'b0;
    tick();
    n_chk++;
    if (a_BSY !== 1'b0 || a_dp_step !== 1'b0 || a_Dvld !== 1'b0 ||
        a_rnd_idx !== 7'd0 || a_z_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL ab_en: got bsy=%b step=%b dv=%b rnd=%0d z=%0d want 0 0 0 0 0",
               a_BSY, a_dp_step, a_Dvld, a_rnd_idx, a_z_idx);
    end
    EN = 1'b1;
    dv = 0;
    bs = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (a_Dvld !== 1'b0) dv++;
      if (a_BSY !== 1'b0) bs++;
    end
    n_chk++;
    if (dv != 0 || bs != 0) begin
      n_fail++;
      $display("FAIL ab_en_quiet: got dvld_cycles=%0d bsy_cycles=%0d want 0 0", dv, bs);
    end
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    for (int e = 1; e <= 21; e++) tick();
    RSTn = 1'b0;
    #1;
    n_chk++;
    if ({a_BSY, a_Dvld, a_Trig, a_dp_load, a_dp_step, a_dp_last,
         a_rnd_idx, a_z_idx} !== 19'd0) begin
      n_fail++;
      $display("FAIL ab_rst: got %b want 0",
               {a_BSY, a_Dvld, a_Trig, a_dp_load, a_dp_step, a_dp_last,
                a_rnd_idx, a_z_idx});
    end
    #2;
    RSTn = 1'b1;
    dv = 0;
    bs = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (a_Dvld !== 1'b0) dv++;
      if (a_BSY !== 1'b0) bs++;
    end
    n_chk++;
    if (dv != 0 || bs != 0) begin
      n_fail++;
      $display("FAIL ab_rst_quiet: got dvld_cycles=%0d bsy_cycles=%0d want 0 0", dv, bs);
    end
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    dv = 0;
    for (int e = 1; e <= 68; e++) begin
      tick();
      if (a_Dvld !== 1'b0) dv++;
    end
    tick();
    n_chk++;
    if (a_Dvld !== 1'b1 || dv != 0) begin
      n_fail++;
      $display("FAIL ab_fresh: got dvld=%b early=%0d want 1 0", a_Dvld, dv);
    end
  endtask

  initial begin
    RSTn = 1'b0;
    EN   = 1'b1;
    Drdy = 1'b0;
    test_reset();
    test_nominal();
    test_z_wrap();
    test_cpr3();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
